// File: rtl/axi_write_master.sv
`default_nettype none
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
// ============================================================================
// Module   : axi_write_master
// Brief    : AXI4 write-only initiator, one outstanding INCR burst of 1-16
//            beats; local request + beat stream in, AW/W/B out, B-status back.
// Revision : 1.0 - initial release
// ============================================================================
module axi_write_master #(
    parameter logic [`AXI_ID_BITS-1:0] M_ID    = `AXI_ID_BITS'(0),
    parameter int                      MAX_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic [3:0]              req_len,
    input  logic [2:0]              req_size,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [31:0]             wd_data,
    input  logic [3:0]              wd_strb,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    busy,
    output logic [`AXI_ID_BITS-1:0] AWID_M,
    output logic [31:0]             AWADDR_M,
    output logic [3:0]              AWLEN_M,
    output logic [2:0]              AWSIZE_M,
    output logic [1:0]              AWBURST_M,
    output logic                    AWVALID_M,
    input  logic                    AWREADY_M,
    output logic [31:0]             WDATA_M,
    output logic [3:0]              WSTRB_M,
    output logic                    WLAST_M,
    output logic                    WVALID_M,
    input  logic                    WREADY_M,
    input  logic [`AXI_ID_BITS-1:0] BID_M,
    input  logic [1:0]              BRESP_M,
    input  logic                    BVALID_M,
    output logic                    BREADY_M
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR_DATA = 3'd1,
        S_DATA_ONLY = 3'd2,
        S_ADDR_ONLY = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        awvalid_q;
    logic        w_open_q;
    logic        bready_q;
    logic        done_valid_q;
    logic        busy_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [1:0]  done_resp_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [2:0]  size_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    logic        aw_hs;
    logic        w_hs;
    logic        w_last;
    logic        aw_fin;
    logic        w_fin;

    assign aw_hs  = awvalid_q & AWREADY_M;
    assign w_hs   = w_open_q & wd_valid & WREADY_M;
    assign w_last = w_open_q & (cnt_q == len_q);
    // Completion of each channel counts whether it happened earlier or right now.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | (w_hs & w_last);
    assign cnt_d  = (w_hs && (cnt_q != CNT_MAX)) ? cnt_q + 4'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            awvalid_q    <= 1'b0;
            w_open_q     <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            done_resp_q  <= 2'b00;
            addr_q       <= 32'd0;
            len_q        <= 4'd0;
            size_q       <= 3'd0;
            cnt_q        <= 4'd0;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= req_valid;
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        len_q       <= req_len;
                        size_q      <= req_size;
                        cnt_q       <= 4'd0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        awvalid_q   <= 1'b1;
                        w_open_q    <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= S_ADDR_DATA;
                    end
                end
                S_ADDR_DATA, S_DATA_ONLY, S_ADDR_ONLY: begin
                    cnt_q     <= cnt_d;
                    aw_done_q <= aw_fin;
                    w_done_q  <= w_fin;
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs && w_last) begin
                        w_open_q <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= S_RESP;
                    end else if (aw_fin) begin
                        state_q <= S_DATA_ONLY;
                    end else if (w_fin) begin
                        state_q <= S_ADDR_ONLY;
                    end
                end
                S_RESP: begin
                    if (BVALID_M) begin
                        bready_q     <= 1'b0;
                        done_valid_q <= 1'b1;
                        // A response carrying a foreign ID cannot be trusted.
                        done_resp_q  <= (BID_M != M_ID) ? 2'b10 : BRESP_M;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    awvalid_q   <= 1'b0;
                    w_open_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;

    assign AWID_M     = M_ID;
    assign AWADDR_M   = addr_q;
    assign AWLEN_M    = len_q;
    assign AWSIZE_M   = size_q;
    assign AWBURST_M  = 2'b01;
    assign AWVALID_M  = awvalid_q;

    assign WVALID_M   = w_open_q & wd_valid;
    assign wd_ready   = w_open_q & WREADY_M;
    assign WDATA_M    = w_open_q ? wd_data : 32'd0;
    assign WSTRB_M    = w_open_q ? wd_strb : 4'd0;
    assign WLAST_M    = w_last;

    assign BREADY_M   = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_write_master.sv
`default_nettype none
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
// ============================================================================
// Module   : tb_axi_write_master
// Brief    : Directed bench for axi_write_master with a transaction-level
//            reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_write_master;

    logic                    clk;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic [3:0]              req_len;
    logic [2:0]              req_size;
    logic                    wd_valid;
    logic                    wd_ready;
    logic [31:0]             wd_data;
    logic [3:0]              wd_strb;
    logic                    done_valid;
    logic [1:0]              done_resp;
    logic                    busy;
    logic [`AXI_ID_BITS-1:0] AWID_M;
    logic [31:0]             AWADDR_M;
    logic [3:0]              AWLEN_M;
    logic [2:0]              AWSIZE_M;
    logic [1:0]              AWBURST_M;
    logic                    AWVALID_M;
    logic                    AWREADY_M;
    logic [31:0]             WDATA_M;
    logic [3:0]              WSTRB_M;
    logic                    WLAST_M;
    logic                    WVALID_M;
    logic                    WREADY_M;
    logic [`AXI_ID_BITS-1:0] BID_M;
    logic [1:0]              BRESP_M;
    logic                    BVALID_M;
    logic                    BREADY_M;

    axi_write_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .done_valid(done_valid), .done_resp(done_resp), .busy(busy),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Source beats and slave behaviour knobs
    logic [31:0] src_data [16];
    logic [3:0]  src_strb [16];
    int          src_n = 0;
    int          src_idx = 0;
    logic        idle_wd = 1'b0;
    int          aw_stall = 0;
    logic        wr_toggle = 1'b0;
    int          b_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [`AXI_ID_BITS-1:0] bid_cfg = '0;
    logic        sl_aw = 1'b0;
    logic        sl_w = 1'b0;

    // Handshakes seen at the last sample point
    logic hs_acc = 1'b0, hs_aw = 1'b0, hs_w = 1'b0, hs_wl = 1'b0, hs_b = 1'b0;

    // Bookkeeping of observed traffic
    int          ncyc = 0;
    int          acc_cnt = 0, aw_cnt = 0, w_cnt = 0, wl_cnt = 0, done_cnt = 0;
    int          acc_cyc = 0, aw_cyc = 0, wl_cyc = 0, done_cyc = 0;
    logic [31:0] last_wdata = '0;
    logic [1:0]  last_resp = '0;

    // Reference model: what the master owes the bus this cycle
    logic        armed = 1'b0;
    logic        m_busy, m_awopen, m_wopen, m_bready, m_done, m_awdone, m_wdone;
    logic [1:0]  m_resp;
    logic [31:0] m_addr;
    logic [3:0]  m_len;
    logic [2:0]  m_size;
    int          m_beats;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic monitor();
        logic e_req_ready, e_awvalid, e_wvalid, e_wd_ready, e_wlast;
        ncyc++;
        e_req_ready = !m_busy || m_done;
        e_awvalid   = m_awopen;
        e_wvalid    = m_wopen & wd_valid;
        e_wd_ready  = m_wopen & WREADY_M;
        e_wlast     = m_wopen & (m_beats == int'(m_len));
        if (armed) begin
            chk("req_ready", req_ready, e_req_ready);
            chk("busy", busy, m_busy);
            chk("awvalid", AWVALID_M, e_awvalid);
            chk("wvalid", WVALID_M, e_wvalid);
            chk("wd_ready", wd_ready, e_wd_ready);
            chk("bready", BREADY_M, m_bready);
            chk("done_valid", done_valid, m_done);
            if (m_done) chk("done_resp", done_resp, m_resp);
            if (m_wopen) chk("wlast", WLAST_M, e_wlast);
            if (e_awvalid) begin
                chk("awaddr", AWADDR_M, m_addr);
                chk("awlen", AWLEN_M, m_len);
                chk("awsize", AWSIZE_M, m_size);
                chk("awid", AWID_M, 0);
                chk("awburst", AWBURST_M, 2'b01);
            end
            if (e_wvalid && e_wd_ready) begin
                chk("wdata", WDATA_M, src_data[m_beats]);
                chk("wstrb", WSTRB_M, src_strb[m_beats]);
            end
        end

        hs_acc = rst & req_valid & req_ready;
        hs_aw  = rst & AWVALID_M & AWREADY_M;
        hs_w   = rst & WVALID_M & WREADY_M;
        hs_wl  = hs_w & WLAST_M;
        hs_b   = rst & BVALID_M & BREADY_M;
        if (hs_acc) begin acc_cnt++; acc_cyc = ncyc; end
        if (hs_aw) begin aw_cnt++; aw_cyc = ncyc; end
        if (hs_w) begin w_cnt++; last_wdata = WDATA_M; end
        if (hs_wl) begin wl_cnt++; wl_cyc = ncyc; end
        if (rst && done_valid) begin done_cnt++; done_cyc = ncyc; last_resp = done_resp; end

        if (!rst) begin
            m_busy = 0; m_awopen = 0; m_wopen = 0; m_bready = 0; m_done = 0;
            m_awdone = 0; m_wdone = 0; m_resp = 2'b00; m_beats = 0;
            m_addr = '0; m_len = '0; m_size = '0;
            armed = 1'b1;
        end else begin
            if (m_done) m_busy = 0;
            m_done = m_bready & BVALID_M;
            if (m_done) begin
                m_resp   = (BID_M != '0) ? 2'b10 : BRESP_M;
                m_bready = 0;
            end
            if (e_awvalid && AWREADY_M) begin m_awopen = 0; m_awdone = 1; end
            if (e_wvalid && e_wd_ready) begin
                if (e_wlast) begin m_wopen = 0; m_wdone = 1; end
                else m_beats++;
            end
            if (m_awdone && m_wdone) begin m_bready = 1; m_awdone = 0; m_wdone = 0; end
            if (req_valid && e_req_ready) begin
                m_busy = 1; m_awopen = 1; m_wopen = 1; m_beats = 0;
                m_addr = req_addr; m_len = req_len; m_size = req_size;
            end
        end
    endtask

    task automatic drive();
        if (hs_w && src_idx < src_n) src_idx++;
        if (src_idx < src_n) begin
            wd_valid = 1'b1; wd_data = src_data[src_idx]; wd_strb = src_strb[src_idx];
        end else begin
            wd_valid = idle_wd; wd_data = 32'hBAD0_0000; wd_strb = 4'h0;
        end
        if (hs_aw) sl_aw = 1'b1;
        if (hs_wl) sl_w = 1'b1;
        AWREADY_M = (aw_stall == 0);
        if (AWVALID_M && aw_stall > 0) aw_stall--;
        WREADY_M = wr_toggle ? ~WREADY_M : 1'b1;
        if (hs_b) begin
            BVALID_M = 1'b0; sl_aw = 1'b0; sl_w = 1'b0;
        end else if (sl_aw && sl_w && !BVALID_M) begin
            if (b_wait > 0) b_wait--;
            else BVALID_M = 1'b1;
        end
        BID_M = bid_cfg;
        BRESP_M = bresp_cfg;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            src_data[i] = base + 32'(i);
            src_strb[i] = 4'hF ^ 4'(i);
        end
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [3:0] l, input logic keep);
        logic got;
        got = 1'b0;
        src_n = int'(l) + 1; src_idx = 0;
        wd_valid = 1'b1; wd_data = src_data[0]; wd_strb = src_strb[0];
        req_valid = 1'b1; req_addr = a; req_len = l; req_size = 3'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_acc) begin got = 1'b1; break; end
        end
        if (!got) chk("accept_timeout", 0, 1);
        req_valid = keep;
    endtask

    task automatic wait_done();
        int d0;
        logic got;
        d0 = done_cnt; got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done_cnt > d0) begin got = 1'b1; break; end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int w0, a0, d0, wl0, c0;
        rst = 1'b0; req_valid = 0; req_addr = '0; req_len = '0; req_size = '0;
        wd_valid = 0; wd_data = '0; wd_strb = '0;
        AWREADY_M = 1; WREADY_M = 1; BVALID_M = 0; BID_M = '0; BRESP_M = '0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", AWVALID_M, 0);
        chk("rst_bready", BREADY_M, 0);
        chk("rst_done_resp", done_resp, 0);
        chk("rst_wd_ready", wd_ready, 0);
        rst = 1'b1;
        tick();

        // 1: single beat, minimum latency
        fill(32'h1, 1);
        w0 = w_cnt;
        start_burst(32'h1000_0100, 4'd0, 1'b0);
        wait_done();
        chk("t1_latency", 32'(done_cyc - acc_cyc), 3);
        chk("t1_resp", last_resp, 2'b00);
        chk("t1_beats", 32'(w_cnt - w0), 1);
        chk("t1_lastdata", last_wdata, 32'h1);
        repeat (2) tick();

        // 2: four beats with WREADY toggling
        fill(32'hA, 4);
        wr_toggle = 1'b1;
        w0 = w_cnt; wl0 = wl_cnt;
        start_burst(32'h2000_0000, 4'd3, 1'b0);
        wait_done();
        wr_toggle = 1'b0;
        chk("t2_beats", 32'(w_cnt - w0), 4);
        chk("t2_wlast_count", 32'(wl_cnt - wl0), 1);
        chk("t2_lastdata", last_wdata, 32'hD);
        repeat (2) tick();

        // 3: W completes long before AW
        fill(32'h11, 3);
        aw_stall = 6;
        start_burst(32'h3000_0040, 4'd2, 1'b0);
        wait_done();
        chk("t3_w_before_aw", 32'(aw_cyc > wl_cyc), 1);
        chk("t3_aw_delay", 32'(aw_cyc - acc_cyc), 7);
        repeat (2) tick();

        // 4: response handling
        fill(32'h40, 2);
        bresp_cfg = 2'b10;
        start_burst(32'h4000_0100, 4'd1, 1'b0);
        wait_done();
        chk("t4_slverr", last_resp, 2'b10);
        bresp_cfg = 2'b00; bid_cfg = `AXI_ID_BITS'(3);
        start_burst(32'h4000_0200, 4'd1, 1'b0);
        wait_done();
        chk("t4_bid_mismatch", last_resp, 2'b10);
        bid_cfg = '0; bresp_cfg = 2'b01; b_wait = 5;
        start_burst(32'h4000_0300, 4'd0, 1'b0);
        wait_done();
        chk("t4_exokay", last_resp, 2'b01);
        chk("t4_bdelay_latency", 32'(done_cyc - acc_cyc), 8);
        bresp_cfg = 2'b00;
        repeat (2) tick();

        // 5: request held while busy, stray beat data while idle
        fill(32'h50, 1);
        aw_stall = 4;
        a0 = aw_cnt; c0 = acc_cnt;
        start_burst(32'h5000_0000, 4'd0, 1'b1);
        repeat (3) tick();
        req_valid = 1'b0;
        wait_done();
        chk("t5_one_aw", 32'(aw_cnt - a0), 1);
        chk("t5_one_accept", 32'(acc_cnt - c0), 1);
        idle_wd = 1'b1; wd_valid = 1'b1;
        w0 = w_cnt;
        repeat (3) tick();
        chk("t5_idle_beats", 32'(w_cnt - w0), 0);
        idle_wd = 1'b0; wd_valid = 1'b0;
        repeat (2) tick();

        // 6: reset in the middle of a burst
        fill(32'h61, 4);
        w0 = w_cnt; d0 = done_cnt;
        start_burst(32'h6000_0000, 4'd3, 1'b0);
        for (int i = 0; i < 20 && (w_cnt - w0) < 2; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        src_n = 0; src_idx = 0; wd_valid = 1'b0;
        sl_aw = 1'b0; sl_w = 1'b0; BVALID_M = 1'b0; aw_stall = 0;
        chk("t6_awvalid", AWVALID_M, 0);
        chk("t6_wvalid", WVALID_M, 0);
        chk("t6_bready", BREADY_M, 0);
        chk("t6_busy", busy, 0);
        chk("t6_req_ready", req_ready, 1);
        repeat (3) tick();
        chk("t6_no_done", 32'(done_cnt - d0), 0);
        fill(32'h71, 2);
        w0 = w_cnt;
        start_burst(32'h6000_1000, 4'd1, 1'b0);
        wait_done();
        chk("t6_after_beats", 32'(w_cnt - w0), 2);
        chk("t6_after_data", last_wdata, 32'h72);
        chk("t6_after_resp", last_resp, 2'b00);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
